// File: rtl/calc_seq.sv
// Program sequencer for the 16-bit calculator ALU: stores (op, operand)
// entries, then replays them through the external ALU into the accumulator.
module calc_seq #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     btnu,
  input  logic                     btnd,
  input  logic                     btnl,
  input  logic                     btnc,
  input  logic                     btnr,
  input  logic [15:0]              sw,
  input  logic                     start,
  input  logic                     step_mode,
  output logic [2:0]               alu_op,
  output logic [15:0]              alu_a,
  output logic [15:0]              alu_b,
  input  logic [15:0]              alu_result,
  output logic [15:0]              led,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] P_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [18:0]   r_buf [DEPTH];
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [15:0]   r_acc;
  logic          r_ovf;
  logic          r_btnd_q;
  logic          r_start_q;

  logic          w_btnd_e;
  logic          w_start_e;
  logic          w_go;
  logic          w_adv;
  logic          w_store;
  logic          w_restart;
  logic          w_reject;
  logic          w_last;
  logic          w_active;
  logic          w_full;
  logic [AW-1:0] w_wr_addr;
  logic [18:0]   w_rd_entry;

  assign w_btnd_e   = btnd & ~r_btnd_q;
  assign w_start_e  = start & ~r_start_q;
  assign w_full     = (r_count == C_FULL);
  assign w_last     = ({1'b0, r_rd_ptr} == (r_count - C_ONE));
  assign w_active   = (r_state == S_RUN) || (r_state == S_WAIT);
  assign w_rd_entry = r_buf[r_rd_ptr];

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // start always beats a coincident btnd edge in LOAD and DONE
  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_adv     = 1'b0;
    w_store   = 1'b0;
    w_restart = 1'b0;
    w_reject  = 1'b0;
    w_wr_addr = r_count[AW-1:0];
    case (r_state)
      S_LOAD: begin
        if (w_start_e && (r_count != '0)) begin
          w_go = 1'b1;
        end else if (w_btnd_e) begin
          if (w_full) w_reject = 1'b1;
          else        w_store  = 1'b1;
        end
      end
      S_RUN: begin
        w_adv = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_WAIT: begin
        if (w_start_e) begin
          w_adv = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_start_e) begin
          w_go = 1'b1;
        end else if (w_btnd_e) begin
          w_restart = 1'b1;
          w_wr_addr = '0;
          w_next    = S_LOAD;
        end
      end
      default: w_next = S_LOAD;
    endcase
    if (w_go) w_next = step_mode ? S_WAIT : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (w_store || w_restart) begin
      r_buf[w_wr_addr] <= {btnl, btnc, btnr, sw};
    end
  end

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_acc     <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_btnd_q  <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_btnd_q  <= btnd;
      r_start_q <= start;
      if (w_go) begin
        r_acc    <= '0;
        r_rd_ptr <= '0;
      end else if (w_adv) begin
        r_acc    <= alu_result;
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      if (w_store)   r_count <= r_count + C_ONE;
      if (w_restart) r_count <= C_ONE;
      if (w_reject)  r_ovf   <= 1'b1;
      if (w_restart) r_ovf   <= 1'b0;
    end
  end

  assign alu_op = w_active ? w_rd_entry[18:16] : 3'b000;
  assign alu_b  = w_active ? w_rd_entry[15:0] : 16'h0000;
  assign alu_a  = r_acc;
  assign led    = r_acc;
  assign count  = r_count;
  assign busy   = w_active;
  assign done   = (r_state == S_DONE);
  assign full   = w_full;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: table of program entries, a combinational ALU
// model, and a queue of expected accumulator values.
module tb_calc_seq;

  logic        clk = 1'b0;
  logic        btnu, btnd, btnl, btnc, btnr;
  logic [15:0] sw;
  logic        start, step_mode;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result, led;
  logic [3:0]  count;
  logic        busy, done, full, ovf;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;
  vec_t prog[5];

  calc_seq #(.DEPTH(8)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd),
    .btnl(btnl), .btnc(btnc), .btnr(btnr),
    .sw(sw), .start(start), .step_mode(step_mode),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .led(led), .count(count),
    .busy(busy), .done(done), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b011: alu_result = alu_a - alu_b;
      3'b100: alu_result = {15'd0, alu_a < alu_b};
      3'b101: alu_result = alu_a << alu_b[3:0];
      3'b110: alu_result = $signed(alu_a) >>> alu_b[3:0];
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: scoreboard empty, led=%h", name, led);
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(led), 32'(e));
    end
  endtask

  task automatic store(logic [2:0] op, logic [15:0] v);
    {btnl, btnc, btnr} = op;
    sw   = v;
    btnd = 1'b1;
    tick();
    btnd = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] s;
    prog[0] = '{3'b010, 16'h354A, 16'h354A};
    prog[1] = '{3'b011, 16'h1234, 16'h2316};
    prog[2] = '{3'b001, 16'h1001, 16'h3317};
    prog[3] = '{3'b000, 16'hF0F0, 16'h3010};
    prog[4] = '{3'b111, 16'h1FA2, 16'h2FB2};

    btnu = 1'b1; btnd = 1'b0; start = 1'b0; step_mode = 1'b0;
    {btnl, btnc, btnr} = 3'b000; sw = 16'h0;
    tick(); tick();
    chk("rst_led",   32'(led), 0);
    chk("rst_alu_op",32'(alu_op), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(ovf), 0);
    btnu = 1'b0;
    tick();

    start = 1'b1; tick();
    chk("empty_start_busy", 32'(busy), 0);
    chk("empty_start_count", 32'(count), 0);
    start = 1'b0; tick();

    for (int i = 0; i < 5; i++) store(prog[i].op, prog[i].b);
    chk("prog_count", 32'(count), 5);
    chk("prog_full", 32'(full), 0);

    // free-running replay
    for (int i = 0; i < 5; i++) sb_q.push_back(prog[i].exp);
    start = 1'b1; tick();
    chk("run_acc0", 32'(led), 0);
    chk("run_busy", 32'(busy), 1);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      sb_check("run_led");
    end
    chk("run_done", 32'(done), 1);
    chk("run_busy_end", 32'(busy), 0);
    chk("run_count", 32'(count), 5);

    // step-mode replay from DONE
    for (int i = 0; i < 5; i++) sb_q.push_back(prog[i].exp);
    step_mode = 1'b1; start = 1'b1; tick();
    chk("step_acc0", 32'(led), 0);
    chk("step_busy0", 32'(busy), 1);
    start = 1'b0; step_mode = 1'b0; tick();
    for (int k = 0; k < 5; k++) begin
      chk("step_alu_b", 32'(alu_b), 32'(prog[k].b));
      chk("step_alu_op", 32'(alu_op), 32'(prog[k].op));
      start = 1'b1; tick();
      sb_check("step_led");
      chk("step_busy", 32'(busy), (k < 4) ? 1 : 0);
      chk("step_done", 32'(done), (k == 4) ? 1 : 0);
      start = 1'b0; tick();
      chk("step_hold", 32'(led), 32'(prog[k].exp));
    end

    // btnd in DONE restarts the buffer with this entry
    store(3'b010, 16'h0005);
    chk("restart_count", 32'(count), 1);
    chk("restart_ovf", 32'(ovf), 0);
    chk("restart_done", 32'(done), 0);
    chk("restart_busy", 32'(busy), 0);
    sb_q.push_back(16'h0005);
    start = 1'b1; tick();
    start = 1'b0; tick();
    sb_check("restart_led");
    chk("restart_run_done", 32'(done), 1);

    // overflow: 9 stores into 8 entries
    btnu = 1'b1; #1; btnu = 1'b0;
    tick();
    for (int i = 1; i <= 9; i++) begin
      store(3'b010, 16'(i));
      if (i == 8) begin
        chk("ovf_before", 32'(ovf), 0);
        chk("full_at8", 32'(full), 1);
      end
    end
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(ovf), 1);
    s = 16'h0;
    for (int i = 1; i <= 8; i++) begin
      s = s + 16'(i);
      sb_q.push_back(s);
    end
    start = 1'b1; tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      sb_check("ovf_run_led");
    end
    chk("ovf_final", 32'(led), 32'h0024);
    chk("ovf_done", 32'(done), 1);

    // asynchronous reset in the middle of a run
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    chk("mid_busy_pre", 32'(busy), 1);
    btnu = 1'b1; #2;
    chk("arst_led", 32'(led), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_alu_b", 32'(alu_b), 0);
    btnu = 1'b0;
    tick();
    start = 1'b1; tick();
    chk("arst_start_busy", 32'(busy), 0);
    chk("arst_start_done", 32'(done), 0);
    start = 1'b0; tick();

    // coincident start and btnd edges in LOAD
    store(3'b010, 16'h0003);
    store(3'b010, 16'h0004);
    sw = 16'h0009;
    start = 1'b1; btnd = 1'b1; tick();
    chk("both_busy", 32'(busy), 1);
    chk("both_count", 32'(count), 2);
    start = 1'b0; btnd = 1'b0;
    sb_q.push_back(16'h0003);
    sb_q.push_back(16'h0007);
    for (int k = 0; k < 2; k++) begin
      tick();
      sb_check("both_led");
    end
    chk("both_done", 32'(done), 1);
    chk("both_count_end", 32'(count), 2);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
